// File: rtl/apb_master_multi.sv
// apb_master_multi: APB requester that fans one request port out to NUM_SLV completers.
//
// The APB address space starts at BASE_ADDR and is split into 2^SLV_SHIFT-byte windows.
// Window i belongs to completer i. An address outside every window is not sent on the bus.
// Instead it completes with error after a single DECERR cycle.
//
// An ACCESS phase that sees no PREADY for TIMEOUT cycles is ended by the block itself,
// and completes with error.
//
// Ports
//   PCLK, PRESET         : clock and synchronous active-high reset
//   PADDR/PWDATA/PSTRB   : latched request fields, held through SETUP and ACCESS
//   PWRITE, PENABLE      : APB control
//   PSEL[NUM_SLV]        : one-hot completer select
//   PRDATA/PREADY/PSLVERR: per-completer response buses (completer i at slice i)
//   transfer + addr/wdata/wstrb/write : request, sampled in IDLE or on a completion cycle
//   ready/rdata/error    : single-cycle completion, combinational on the completing cycle
module apb_master_multi #(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned SLV_SHIFT = 12,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  // APB requester side
  output logic [31:0]            PADDR,
  output logic [31:0]            PWDATA,
  output logic [3:0]             PSTRB,
  output logic                   PWRITE,
  output logic                   PENABLE,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [NUM_SLV*32-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY,
  input  logic [NUM_SLV-1:0]     PSLVERR,
  // Request / completion side
  input  logic                   transfer,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   write,
  output logic                   ready,
  output logic [31:0]            rdata,
  output logic                   error
);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDecerr
  } state_e;

  state_e              state_q;
  logic [31:0]         paddr_q;
  logic [31:0]         pwdata_q;
  logic [3:0]          pstrb_q;
  logic                pwrite_q;
  logic                penable_q;
  logic [NUM_SLV-1:0]  psel_q;
  logic [7:0]          cnt_q;

  // Request decode
  logic [31:0]         req_offset;
  logic [31:0]         req_slot;
  logic                req_mapped;
  logic [NUM_SLV-1:0]  req_psel;

  always_comb begin
    req_offset = addr - BASE_ADDR;
    req_slot   = req_offset >> SLV_SHIFT;
    req_mapped = (addr >= BASE_ADDR) && (req_slot < NUM_SLV);
    req_psel   = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      req_psel[i] = req_mapped && (req_slot == 32'(i));
    end
  end

  // The selected completer's response is picked with the registered one-hot PSEL.
  // This makes the response of an unselected completer irrelevant by construction.
  logic        sel_ready;
  logic        sel_err;
  logic [31:0] sel_rdata;

  always_comb begin
    sel_ready = |(PREADY & psel_q);
    sel_err   = |(PSLVERR & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) begin
        sel_rdata = sel_rdata | PRDATA[32*i +: 32];
      end
    end
  end

  // Completion conditions
  logic timed_out;
  logic access_done;
  logic completing;
  logic take_req;

  always_comb begin
    timed_out   = (cnt_q == 8'(TIMEOUT - 1)) && !sel_ready;
    access_done = (state_q == StAccess) && (sel_ready || timed_out);
    completing  = access_done || (state_q == StDecerr);
    // A new request is accepted in IDLE or on a completion cycle (back-to-back).
    take_req    = transfer && ((state_q == StIdle) || completing);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      cnt_q     <= '0;
    end else if (take_req) begin
      paddr_q   <= addr;
      pwdata_q  <= wdata;
      pstrb_q   <= write ? wstrb : 4'b0000;
      pwrite_q  <= write;
      penable_q <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= req_psel;
      state_q   <= req_mapped ? StSetup : StDecerr;
    end else begin
      unique case (state_q)
        StIdle: begin
          psel_q    <= '0;
          penable_q <= 1'b0;
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (access_done) begin
            state_q   <= StIdle;
            psel_q    <= '0;
            penable_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDecerr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          psel_q    <= '0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs
  logic active;

  always_comb begin
    active  = (state_q == StSetup) || (state_q == StAccess);
    PADDR   = paddr_q;
    PWDATA  = pwdata_q;
    PSTRB   = pstrb_q;
    PWRITE  = pwrite_q && active;
    PENABLE = penable_q;
    PSEL    = psel_q;

    // A reset cycle aborts the transfer, so it never reports a completion.
    ready = completing && !PRESET;

    error = 1'b0;
    rdata = '0;
    if (ready) begin
      if ((state_q == StAccess) && sel_ready) begin
        error = sel_err;
        rdata = pwrite_q ? 32'h0 : sel_rdata;
      end else begin
        // Timeout or decode error
        error = 1'b1;
      end
    end
  end

  // PSEL never selects more than one completer.
  a_psel_onehot: assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(PSEL));
  // PENABLE is only raised while a completer is selected.
  a_penable_sel: assert property (@(posedge PCLK) disable iff (PRESET) PENABLE |-> (|PSEL));

endmodule

// File: tb/tb_apb_master_multi.sv
// Bench for apb_master_multi. Inputs change 1 time unit after the rising edge,
// and outputs are sampled on the falling edge. Each expected completion is
// pushed to a queue when its request is driven. The queue entry is popped
// when ready is seen.
module tb_apb_master_multi;

  localparam int unsigned NS = 4;

  logic             PCLK;
  logic             PRESET;
  logic [31:0]      PADDR;
  logic [31:0]      PWDATA;
  logic [3:0]       PSTRB;
  logic             PWRITE;
  logic             PENABLE;
  logic [NS-1:0]    PSEL;
  logic [NS*32-1:0] PRDATA;
  logic [NS-1:0]    PREADY;
  logic [NS-1:0]    PSLVERR;
  logic             transfer;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             write;
  logic             ready;
  logic [31:0]      rdata;
  logic             error;

  apb_master_multi #(
    .NUM_SLV  (NS),
    .BASE_ADDR(32'h1000_0000),
    .SLV_SHIFT(12),
    .TIMEOUT  (16)
  ) u_dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .transfer(transfer),
    .addr    (addr),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .write   (write),
    .ready   (ready),
    .rdata   (rdata),
    .error   (error)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    if (ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_ready", 32'(ready), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_rdata", rdata, e.rdata);
        check_eq("sb_error", 32'(error), 32'(e.err));
      end
    end
  end

  task automatic next_cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s);
    transfer = 1'b1;
    addr     = a;
    write    = w;
    wdata    = d;
    wstrb    = s;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    sb_q.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] derr_addr [3];

  initial begin
    derr_addr[0] = 32'h2000_0000;
    derr_addr[1] = 32'h1000_4000;
    derr_addr[2] = 32'h0FFF_FFFC;

    PRESET   = 1'b1;
    PRDATA   = '0;
    PREADY   = '0;
    PSLVERR  = '0;
    transfer = 1'b0;
    addr     = '0;
    wdata    = '0;
    wstrb    = '0;
    write    = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_psel", 32'(PSEL), 32'h0);
    check_eq("rst_penable", 32'(PENABLE), 32'h0);
    check_eq("rst_pwrite", 32'(PWRITE), 32'h0);
    check_eq("rst_ready", 32'(ready), 32'h0);
    check_eq("rst_error", 32'(error), 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_paddr", PADDR, 32'h0);

    // Write to completer 2 with zero wait states
    next_cycle();
    req(32'h1000_2004, 1'b1, 32'hDEAD_BEEF, 4'hF);
    PREADY = 4'b0100;
    push_exp(32'h0, 1'b0);
    @(negedge PCLK);
    check_eq("wr_idle_psel", 32'(PSEL), 32'h0);
    next_cycle();
    transfer = 1'b0;
    @(negedge PCLK);
    check_eq("wr_setup_psel", 32'(PSEL), 32'h4);
    check_eq("wr_setup_penable", 32'(PENABLE), 32'h0);
    check_eq("wr_setup_ready", 32'(ready), 32'h0);
    check_eq("wr_setup_paddr", PADDR, 32'h1000_2004);
    check_eq("wr_setup_pwrite", 32'(PWRITE), 32'h1);
    next_cycle();
    @(negedge PCLK);
    check_eq("wr_access_psel", 32'(PSEL), 32'h4);
    check_eq("wr_access_penable", 32'(PENABLE), 32'h1);
    check_eq("wr_access_ready", 32'(ready), 32'h1);
    check_eq("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
    check_eq("wr_access_pstrb", 32'(PSTRB), 32'hF);
    next_cycle();
    PREADY = '0;
    @(negedge PCLK);
    check_eq("wr_done_psel", 32'(PSEL), 32'h0);
    check_eq("wr_done_pwrite", 32'(PWRITE), 32'h0);
    check_eq("wr_done_ready", 32'(ready), 32'h0);
    check_eq("wr_done_paddr_held", PADDR, 32'h1000_2004);

    // Read from completer 1, ready on the 3rd ACCESS cycle
    next_cycle();
    req(32'h1000_1010, 1'b0, 32'h0, 4'hF);
    push_exp(32'h1234_5678, 1'b0);
    @(negedge PCLK);
    next_cycle();
    transfer = 1'b0;
    @(negedge PCLK);
    check_eq("rd_setup_psel", 32'(PSEL), 32'h2);
    check_eq("rd_setup_pstrb", 32'(PSTRB), 32'h0);
    check_eq("rd_setup_pwrite", 32'(PWRITE), 32'h0);
    next_cycle();
    PREADY  = 4'b0001;  // unselected completer responds
    PSLVERR = 4'b0001;
    @(negedge PCLK);
    check_eq("rd_acc1_ready", 32'(ready), 32'h0);
    next_cycle();
    PREADY  = '0;
    PSLVERR = '0;
    @(negedge PCLK);
    check_eq("rd_acc2_ready", 32'(ready), 32'h0);
    next_cycle();
    PREADY = 4'b0010;
    PRDATA[32 +: 32] = 32'h1234_5678;
    PRDATA[0 +: 32]  = 32'hFFFF_FFFF;
    @(negedge PCLK);
    check_eq("rd_acc3_ready", 32'(ready), 32'h1);
    check_eq("rd_acc3_penable", 32'(PENABLE), 32'h1);
    next_cycle();
    PREADY = '0;
    @(negedge PCLK);
    check_eq("rd_done_psel", 32'(PSEL), 32'h0);

    // Decode errors: above the top window, at the first unmapped window, below base
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req(derr_addr[k], 1'b0, 32'h0, 4'h0);
      push_exp(32'h0, 1'b1);
      @(negedge PCLK);
      check_eq("derr_idle_ready", 32'(ready), 32'h0);
      next_cycle();
      transfer = 1'b0;
      @(negedge PCLK);
      check_eq("derr_psel", 32'(PSEL), 32'h0);
      check_eq("derr_ready", 32'(ready), 32'h1);
      check_eq("derr_error", 32'(error), 32'h1);
      next_cycle();
      @(negedge PCLK);
      check_eq("derr_after_ready", 32'(ready), 32'h0);
    end

    // Timeout on completer 0
    next_cycle();
    req(32'h1000_0000, 1'b0, 32'h0, 4'h0);
    PRDATA[0 +: 32] = 32'hAAAA_5555;
    push_exp(32'h0, 1'b1);
    @(negedge PCLK);
    next_cycle();
    transfer = 1'b0;
    @(negedge PCLK);
    check_eq("to_setup_psel", 32'(PSEL), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      @(negedge PCLK);
      check_eq("to_access_ready", 32'(ready), (k == 16) ? 32'h1 : 32'h0);
    end
    next_cycle();
    PREADY = 4'b0001;  // late response
    @(negedge PCLK);
    check_eq("to_after_psel", 32'(PSEL), 32'h0);
    check_eq("to_late_ready", 32'(ready), 32'h0);
    next_cycle();
    PREADY = '0;

    // Back-to-back: write to completer 0, then read from completer 3 with slave error
    req(32'h1000_0000, 1'b1, 32'h1111_1111, 4'h3);
    PREADY  = 4'b1001;
    PSLVERR = 4'b1000;
    PRDATA[96 +: 32] = 32'hCAFE_F00D;
    push_exp(32'h0, 1'b0);
    @(negedge PCLK);
    next_cycle();
    req(32'h1000_3008, 1'b0, 32'h0, 4'hF);  // ignored in SETUP
    push_exp(32'hCAFE_F00D, 1'b1);
    @(negedge PCLK);
    check_eq("b2b_setup0_psel", 32'(PSEL), 32'h1);
    check_eq("b2b_setup0_paddr", PADDR, 32'h1000_0000);
    check_eq("b2b_setup0_pstrb", 32'(PSTRB), 32'h3);
    next_cycle();
    @(negedge PCLK);
    check_eq("b2b_access0_psel", 32'(PSEL), 32'h1);
    check_eq("b2b_access0_ready", 32'(ready), 32'h1);
    next_cycle();
    transfer = 1'b0;
    @(negedge PCLK);
    check_eq("b2b_setup3_psel", 32'(PSEL), 32'h8);
    check_eq("b2b_setup3_penable", 32'(PENABLE), 32'h0);
    check_eq("b2b_setup3_paddr", PADDR, 32'h1000_3008);
    next_cycle();
    @(negedge PCLK);
    check_eq("b2b_access3_ready", 32'(ready), 32'h1);
    next_cycle();
    PREADY  = '0;
    PSLVERR = '0;
    @(negedge PCLK);
    check_eq("b2b_done_psel", 32'(PSEL), 32'h0);

    // Reset during ACCESS, then a fresh transfer
    next_cycle();
    req(32'h1000_1000, 1'b0, 32'h0, 4'h0);
    @(negedge PCLK);
    next_cycle();
    transfer = 1'b0;
    @(negedge PCLK);
    next_cycle();
    @(negedge PCLK);
    check_eq("rst_mid_access_penable", 32'(PENABLE), 32'h1);
    next_cycle();
    PRESET = 1'b1;
    @(negedge PCLK);
    check_eq("rst_mid_hold_ready", 32'(ready), 32'h0);
    next_cycle();
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_mid_psel", 32'(PSEL), 32'h0);
    check_eq("rst_mid_penable", 32'(PENABLE), 32'h0);
    check_eq("rst_mid_ready", 32'(ready), 32'h0);
    check_eq("rst_mid_paddr", PADDR, 32'h0);
    next_cycle();
    req(32'h1000_2000, 1'b1, 32'h5A5A_5A5A, 4'h1);
    PREADY = 4'b0100;
    push_exp(32'h0, 1'b0);
    @(negedge PCLK);
    next_cycle();
    transfer = 1'b0;
    @(negedge PCLK);
    check_eq("post_rst_setup_psel", 32'(PSEL), 32'h4);
    next_cycle();
    @(negedge PCLK);
    check_eq("post_rst_access_ready", 32'(ready), 32'h1);
    check_eq("post_rst_pstrb", 32'(PSTRB), 32'h1);
    next_cycle();
    PREADY = '0;
    @(negedge PCLK);
    check_eq("post_rst_done_psel", 32'(PSEL), 32'h0);

    next_cycle();
    @(negedge PCLK);
    check_eq("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
